acc_dma_ctrl: RTL and testbench

Initiator/driver for the matrix accelerator wrapper (start/done, 256-word A/B/C arrays of 4x8-bit words).
- Accepts a command: base addresses for A, B and C, plus a word count.
- Fetches A and B from data memory over a req/gnt/rvalid master port and presents them on the accelerator input arrays.
- Raises start, waits for done, then writes C back to memory.
- Sits between the core-side config registers and the accelerator; it is the other end of the start/done and matrix-array interface.

---
 rtl/acc_dma_ctrl_pkg.sv | 18 +
 rtl/acc_dma_ctrl_if.sv | 23 ++
 rtl/acc_mem_port.sv | 42 ++++
 rtl/acc_dma_ctrl.sv | 152 +++++++++++++++
 tb/tb_acc_dma_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_dma_ctrl_pkg.sv
// Shared types and FSM encodings for the matrix accelerator DMA controller.
package acc_pkg;

    localparam int MAT_WORDS = 256;

    typedef logic [3:0][7:0] acc_word_t;

    typedef enum logic {PH_A, PH_B} phase_t;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] COMPUTE = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_WAIT = 3'd5;
    localparam logic [2:0] FINISH  = 3'd6;

endpackage

// File: rtl/acc_dma_ctrl_if.sv
// Data-memory req/gnt/rvalid bus between the DMA controller and memory.
interface acc_dma_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/acc_mem_port.sv
// Single-outstanding req/gnt/rvalid master driven by a go/we/addr/wdata command.
// Latency: request combinational from go; ack is the rvalid cycle of the granted transfer.
// Backpressure: request held stable until gnt; no new request while a response is pending.
module acc_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              issued,
    output logic              ack,
    output logic [31:0]       rdata,
    acc_dma_ctrl_if.master    bus
);

    logic pend;

    // Bus fields are zeroed outside a request so idle outputs read as 0.
    assign bus.mem_req   = go & ~pend;
    assign bus.mem_we    = bus.mem_req & we;
    assign bus.mem_be    = bus.mem_req ? 4'hF : 4'h0;
    assign bus.mem_addr  = bus.mem_req ? addr : '0;
    assign bus.mem_wdata = (bus.mem_req & we) ? wdata : '0;

    assign issued = bus.mem_req & bus.mem_gnt;
    assign ack    = pend & bus.mem_rvalid;
    assign rdata  = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (issued) begin
            pend <= 1'b1;
        end else if (ack) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/acc_dma_ctrl.sv
// Loads A/B from memory into the accelerator arrays, runs start/done, writes C back.
// Latency: 1 + 4N + T_acc + 2N + 1 cycles with zero-wait memory.
// Backpressure: cmd_ready only in IDLE; memory stalls on gnt/rvalid; watchdog aborts a stuck compute.
module acc_dma_ctrl
    import acc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAT_WORDS = acc_pkg::MAT_WORDS,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base_a,
    input  logic [ADDR_W-1:0] cmd_base_b,
    input  logic [ADDR_W-1:0] cmd_base_c,
    input  logic [8:0]        cmd_words,
    output logic              busy,
    output logic              done_pulse,
    output logic              timeout_pulse,
    acc_dma_ctrl_if.master    mem,
    output logic              acc_start,
    input  logic              acc_done,
    output acc_word_t         acc_in_A [MAT_WORDS],
    output acc_word_t         acc_in_B [MAT_WORDS],
    input  acc_word_t         acc_out  [MAT_WORDS]
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [2:0]        state;
    phase_t            phase;
    logic [8:0]        i;
    logic [8:0]        n;
    logic [ADDR_W-1:0] base_a, base_b, base_c;
    logic [CW-1:0]     cnt;
    logic              tpulse;
    logic              go, we, issued, ack, last;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rdata;

    assign last = (i == n - 9'd1);

    always_comb begin
        go   = (state == RD_REQ) || (state == WR_REQ);
        we   = (state == WR_REQ);
        addr = ((state == WR_REQ) ? base_c : ((phase == PH_A) ? base_a : base_b))
             + (ADDR_W'(i) << 2);
    end

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    // Held through the write-back so the accelerator keeps acc_out stable.
    assign acc_start     = (state == COMPUTE) || (state == WR_REQ) || (state == WR_WAIT);
    assign done_pulse    = (state == FINISH);
    assign timeout_pulse = tpulse;

    acc_mem_port #(.ADDR_W(ADDR_W)) u_port (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .we     (we),
        .addr   (addr),
        .wdata  (acc_out[i[7:0]]),
        .issued (issued),
        .ack    (ack),
        .rdata  (rdata),
        .bus    (mem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= PH_A;
            i      <= '0;
            n      <= '0;
            base_a <= '0;
            base_b <= '0;
            base_c <= '0;
            cnt    <= '0;
            tpulse <= 1'b0;
            for (int k = 0; k < MAT_WORDS; k++) begin
                acc_in_A[k] <= '0;
                acc_in_B[k] <= '0;
            end
        end else begin
            tpulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        base_a <= cmd_base_a;
                        base_b <= cmd_base_b;
                        base_c <= cmd_base_c;
                        n      <= (cmd_words == 9'd0) ? 9'd256 : cmd_words;
                        i      <= '0;
                        phase  <= PH_A;
                        state  <= RD_REQ;
                        for (int k = 0; k < MAT_WORDS; k++) begin
                            acc_in_A[k] <= '0;
                            acc_in_B[k] <= '0;
                        end
                    end
                end
                RD_REQ: if (issued) state <= RD_WAIT;
                RD_WAIT: begin
                    if (ack) begin
                        if (phase == PH_A) acc_in_A[i[7:0]] <= rdata;
                        else               acc_in_B[i[7:0]] <= rdata;
                        if (last && phase == PH_A) begin
                            phase <= PH_B;
                            i     <= '0;
                            state <= RD_REQ;
                        end else if (last) begin
                            cnt   <= '0;
                            state <= COMPUTE;
                        end else begin
                            i     <= i + 9'd1;
                            state <= RD_REQ;
                        end
                    end
                end
                COMPUTE: begin
                    if (acc_done) begin
                        i     <= '0;
                        state <= WR_REQ;
                    end else if (TIMEOUT != 0 && cnt == TMO_LAST) begin
                        tpulse <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WR_REQ: if (issued) state <= WR_WAIT;
                WR_WAIT: begin
                    if (ack) begin
                        if (last) begin
                            state <= FINISH;
                        end else begin
                            i     <= i + 9'd1;
                            state <= WR_REQ;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_dma_ctrl.sv
// Directed bench for acc_dma_ctrl with a negedge memory model and a delayed-done accelerator model.
module tb_acc_dma_ctrl;
    import acc_pkg::*;

    localparam int ACC_DLY = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_base_a = '0, cmd_base_b = '0, cmd_base_c = '0;
    logic [8:0]  cmd_words = '0;
    logic        busy, done_pulse, timeout_pulse, acc_start;
    logic        acc_done = 1'b0;
    acc_word_t   acc_in_A [256];
    acc_word_t   acc_in_B [256];
    acc_word_t   acc_out  [256];

    acc_dma_ctrl_if #(.ADDR_W(32)) mem ();

    acc_dma_ctrl #(.ADDR_W(32), .MAT_WORDS(256), .TIMEOUT(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_a    (cmd_base_a),
        .cmd_base_b    (cmd_base_b),
        .cmd_base_c    (cmd_base_c),
        .cmd_words     (cmd_words),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .timeout_pulse (timeout_pulse),
        .mem           (mem),
        .acc_start     (acc_start),
        .acc_done      (acc_done),
        .acc_in_A      (acc_in_A),
        .acc_in_B      (acc_in_B),
        .acc_out       (acc_out)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return 32'h01020304 + (a - 32'h100) * 32'h01010101;
    endfunction

    function automatic logic [31:0] wr_val(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8'hC0, b, 8'h5A, ~b};
    endfunction

    // ---------------- memory model ----------------
    bit          rand_mode = 0, never_done = 0;
    int          rv_fix = 1;
    logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$];
    int          stab_err = 0, outst_err = 0, be_err = 0;
    bit          pend = 0, p_req = 0;
    int          gd = -1, rv_cnt = 0;
    logic        pend_we, p_we;
    logic [31:0] pend_addr, p_addr, p_wdata;

    always @(negedge clk) begin
        mem.mem_gnt    = 1'b0;
        mem.mem_rvalid = 1'b0;
        if (rst) begin
            pend = 0; gd = -1; p_req = 0;
        end else begin
            if (pend && mem.mem_req) outst_err++;
            if (p_req && !(mem.mem_req && mem.mem_addr == p_addr && mem.mem_we == p_we
                           && mem.mem_wdata == p_wdata)) stab_err++;
            if (pend) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = pend_we ? 32'h0 : rd_val(pend_addr);
                    pend = 0;
                end
            end else if (mem.mem_req) begin
                if (gd < 0) gd = rand_mode ? int'($urandom_range(0, 5)) : 0;
                if (gd == 0) begin
                    mem.mem_gnt = 1'b1;
                    gd = -1; pend = 1;
                    pend_we = mem.mem_we; pend_addr = mem.mem_addr;
                    rv_cnt = rand_mode ? int'($urandom_range(1, 4)) : rv_fix;
                    if (mem.mem_be != 4'hF) be_err++;
                    if (mem.mem_we) begin
                        wr_a_q.push_back(mem.mem_addr);
                        wr_d_q.push_back(mem.mem_wdata);
                    end else begin
                        rd_q.push_back(mem.mem_addr);
                    end
                end else begin
                    gd--;
                end
            end
            p_req = mem.mem_req && !mem.mem_gnt;
            p_addr = mem.mem_addr; p_we = mem.mem_we; p_wdata = mem.mem_wdata;
        end
    end

    // ---------------- accelerator model ----------------
    int sc = 0;
    always @(negedge clk) begin
        if (rst || !acc_start) begin
            sc = 0; acc_done = 1'b0;
        end else begin
            sc++;
            acc_done = !never_done && (sc >= ACC_DLY);
        end
    end

    // ---------------- event monitor ----------------
    longint acc_q[$], dn_q[$], to_q[$];
    longint start_cyc = 0;
    logic   to_start = 1'b1;
    int     min_gap = 1000, low_run = 0;
    bit     seen_start = 0, prev_start = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (done_pulse) dn_q.push_back(cyc);
            if (timeout_pulse) begin to_q.push_back(cyc); to_start = acc_start; end
            if (acc_start && !prev_start) begin
                start_cyc = cyc;
                if (seen_start && low_run < min_gap) min_gap = low_run;
                seen_start = 1;
            end
            low_run = acc_start ? 0 : low_run + 1;
            prev_start = acc_start;
        end
    end

    task automatic clr();
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
        acc_q.delete(); dn_q.delete(); to_q.delete();
        stab_err = 0; outst_err = 0; be_err = 0;
        min_gap = 1000; seen_start = 0;
    endtask

    task automatic start_cmd(input logic [31:0] a, b, c, input logic [8:0] w);
        @(posedge clk); #1;
        cmd_base_a = a; cmd_base_b = b; cmd_base_c = c; cmd_words = w;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ev(input string tag, input int want, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (dn_q.size() + to_q.size() >= want) return;
        end
        chk(tag, 0, 1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) acc_out[k] = wr_val(k);

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem.mem_req, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_tmo", timeout_pulse, 0);
        chk("rst_A0", acc_in_A[0], 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // N=4, zero-wait memory
        clr();
        start_cmd(32'h100, 32'h200, 32'h300, 9'd4);
        wait_ev("t1_wait", 1, 500);
        chk("t1_nrd", rd_q.size(), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t1_rd%0d", k), rd_q[k],
                (k < 4) ? 32'h100 + 4 * k : 32'h200 + 4 * (k - 4));
        chk("t1_A0", acc_in_A[0], 32'h01020304);
        chk("t1_A1", acc_in_A[1], 32'h05060708);
        chk("t1_B0", acc_in_B[0], 32'h02030404);
        chk("t1_A4_zero", acc_in_A[4], 0);
        chk("t1_nwr", wr_a_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_wa%0d", k), wr_a_q[k], 32'h300 + 4 * k);
            chk($sformatf("t1_wd%0d", k), wr_d_q[k], wr_val(k));
        end
        chk("t1_latency", dn_q[0] - acc_q[0], 1 + 16 + 10 + 8);
        chk("t1_errs", stab_err + outst_err + be_err, 0);

        // cmd_words=0 means 256
        clr();
        start_cmd(32'h1000, 32'h2000, 32'h3000, 9'd0);
        wait_ev("t2_wait", 1, 3000);
        chk("t2_nrd", rd_q.size(), 512);
        chk("t2_rdA_last", rd_q[255], 32'h13FC);
        chk("t2_rdB_first", rd_q[256], 32'h2000);
        chk("t2_rdB_last", rd_q[511], 32'h23FC);
        chk("t2_A255", acc_in_A[255], rd_val(32'h13FC));
        chk("t2_nwr", wr_a_q.size(), 256);
        chk("t2_wa_last", wr_a_q[255], 32'h33FC);
        chk("t2_wd_last", wr_d_q[255], wr_val(255));
        chk("t2_latency", dn_q[0] - acc_q[0], 1 + 1024 + 10 + 512);

        // random gnt/rvalid delays, N=8
        clr();
        rand_mode = 1;
        start_cmd(32'h400, 32'h500, 32'h600, 9'd8);
        wait_ev("t3_wait", 1, 2000);
        rand_mode = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_A%0d", k), acc_in_A[k], rd_val(32'h400 + 4 * k));
            chk($sformatf("t3_B%0d", k), acc_in_B[k], rd_val(32'h500 + 4 * k));
        end
        chk("t3_A8_zero", acc_in_A[8], 0);
        chk("t3_nwr", wr_a_q.size(), 8);
        chk("t3_wa7", wr_a_q[7], 32'h61C);
        chk("t3_wd5", wr_d_q[5], wr_val(5));
        chk("t3_stable", stab_err, 0);
        chk("t3_outstanding", outst_err, 0);
        chk("t3_be", be_err, 0);

        // watchdog
        clr();
        never_done = 1;
        start_cmd(32'h100, 32'h200, 32'h300, 9'd2);
        wait_ev("t4_wait", 1, 500);
        never_done = 0;
        chk("t4_ntmo", to_q.size(), 1);
        chk("t4_ndone", dn_q.size(), 0);
        chk("t4_tmo_cycle", to_q[0] - start_cyc, 20);
        chk("t4_start_low", to_start, 0);
        chk("t4_nwr", wr_a_q.size(), 0);
        #2;
        chk("t4_cmd_ready", cmd_ready, 1);
        chk("t4_busy", busy, 0);

        // reset during phase-B read wait
        clr();
        rv_fix = 3;
        start_cmd(32'h100, 32'h200, 32'h300, 9'd4);
        for (int k = 0; k < 200 && rd_q.size() < 6; k++) @(posedge clk);
        chk("t5_reached_B", rd_q.size(), 6);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_mem_req", mem.mem_req, 0);
        chk("t5_acc_start", acc_start, 0);
        chk("t5_busy", busy, 0);
        chk("t5_A0_zero", acc_in_A[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rv_fix = 1;
        clr();
        start_cmd(32'h800, 32'h900, 32'hA00, 9'd2);
        wait_ev("t5_wait", 1, 500);
        chk("t5_ndone", dn_q.size(), 1);
        chk("t5_A1", acc_in_A[1], rd_val(32'h804));
        chk("t5_nwr", wr_a_q.size(), 2);
        chk("t5_wa1", wr_a_q[1], 32'hA04);

        // cmd_valid held high across two runs
        clr();
        @(posedge clk); #1;
        cmd_base_a = 32'h100; cmd_base_b = 32'h200; cmd_base_c = 32'h300; cmd_words = 9'd2;
        cmd_valid = 1'b1;
        for (int k = 0; k < 500 && acc_q.size() < 2; k++) @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_ev("t6_wait", 2, 500);
        chk("t6_naccept", acc_q.size(), 2);
        chk("t6_ndone", dn_q.size(), 2);
        chk("t6_accept_after_done", acc_q[1] - dn_q[0], 1);
        chk("t6_gap_ok", min_gap >= 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
